mem_wb_stage: RTL and testbench

Memory-to-writeback stage of the five-stage RV32I pipeline. Accepts the instruction leaving MEM, waits for data-memory read data on loads, extracts and sign- or zero-extends load bytes/halfwords, and selects the writeback value. It registers rdAddr_wb, RegWrite_wb and RegWriteData_wb, which feed the register file's write port and its write-to-read bypass. It stalls MEM and upstream stages while a load is outstanding, and flags a sticky error if memory never responds.

---
 rtl/mem_wb_stage.sv | 137 +++++++++++++
 tb/tb_mem_wb_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: waits on data-memory reads, extracts load bytes and halfwords,
// and registers the writeback port. It raises a sticky flag when a load is abandoned.
module mem_wb_stage #(
    parameter int unsigned LOAD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_mem,
    input  logic        RegWrite_mem,
    input  logic [4:0]  rdAddr_mem,
    input  logic        MemRead_mem,
    input  logic [2:0]  funct3_mem,
    input  logic [1:0]  addrLow_mem,
    input  logic [1:0]  WbSel_mem,
    input  logic [31:0] AluResult_mem,
    input  logic [31:0] PcPlus4_mem,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_rvalid,
    output logic        stall_mem,
    output logic        RegWrite_wb,
    output logic [4:0]  rdAddr_wb,
    output logic [31:0] RegWriteData_wb,
    output logic        loadTimeout
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = (LOAD_TIMEOUT < 1) ? 1 : $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOAD_TIMEOUT);

    typedef enum logic [0:0] {
        IDLE,
        WAIT_LOAD
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;

    logic               load_pending;
    logic               timeout_hit;
    logic               abandon;
    logic               capture;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [DATA_W-1:0]  load_data;
    logic [DATA_W-1:0]  wb_data;

    // Stall and timeout qualifiers; read data arriving on the timeout cycle still wins.
    always_comb begin
        load_pending = valid_mem & MemRead_mem & ~dmem_rvalid;
        timeout_hit  = (state == WAIT_LOAD) && (cnt == CNT_MAX);
        abandon      = timeout_hit & load_pending;
        stall_mem    = load_pending & ~timeout_hit & ~rst;
        capture      = valid_mem & ~stall_mem & ~abandon;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (load_pending) begin
                    state_n = WAIT_LOAD;
                    cnt_n   = CNT_W'(1);
                end
            end
            WAIT_LOAD: begin
                cnt_n = cnt + CNT_W'(1);
                if (dmem_rvalid || timeout_hit || !valid_mem) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Load lane extraction; the halfword ignores addrLow[0].
    always_comb begin
        byte_sel = dmem_rdata[{addrLow_mem, 3'b000} +: 8];
        half_sel = dmem_rdata[{addrLow_mem[1], 4'b0000} +: 16];
        case (funct3_mem)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        case (WbSel_mem)
            2'b01:   wb_data = load_data;
            2'b10:   wb_data = PcPlus4_mem;
            default: wb_data = AluResult_mem;
        endcase
    end

    // Bubbles clear the write enable only; address and data hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite_wb     <= 1'b0;
            rdAddr_wb       <= '0;
            RegWriteData_wb <= '0;
        end else if (capture) begin
            RegWrite_wb     <= RegWrite_mem & (rdAddr_mem != REG_W'(0));
            rdAddr_wb       <= rdAddr_mem;
            RegWriteData_wb <= wb_data;
        end else begin
            RegWrite_wb     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            loadTimeout <= 1'b0;
        end else if (abandon) begin
            loadTimeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage against a transaction-level reference model.
module tb_mem_wb_stage;

    localparam int unsigned T = 4;
    localparam int NEVER = 99;

    logic        clk;
    logic        rst;
    logic        valid_mem;
    logic        RegWrite_mem;
    logic [4:0]  rdAddr_mem;
    logic        MemRead_mem;
    logic [2:0]  funct3_mem;
    logic [1:0]  addrLow_mem;
    logic [1:0]  WbSel_mem;
    logic [31:0] AluResult_mem;
    logic [31:0] PcPlus4_mem;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;
    logic        stall_mem;
    logic        RegWrite_wb;
    logic [4:0]  rdAddr_wb;
    logic [31:0] RegWriteData_wb;
    logic        loadTimeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model of the architectural WB outputs
    logic        m_rw;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_to;

    mem_wb_stage #(.LOAD_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .valid_mem(valid_mem), .RegWrite_mem(RegWrite_mem),
        .rdAddr_mem(rdAddr_mem), .MemRead_mem(MemRead_mem), .funct3_mem(funct3_mem),
        .addrLow_mem(addrLow_mem), .WbSel_mem(WbSel_mem), .AluResult_mem(AluResult_mem),
        .PcPlus4_mem(PcPlus4_mem), .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
        .stall_mem(stall_mem), .RegWrite_wb(RegWrite_wb), .rdAddr_wb(rdAddr_wb),
        .RegWriteData_wb(RegWriteData_wb), .loadTimeout(loadTimeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_wb(input string tag);
        check({tag, "_rw"},   32'(RegWrite_wb),  32'(m_rw));
        check({tag, "_rd"},   32'(rdAddr_wb),    32'(m_rd));
        check({tag, "_data"}, RegWriteData_wb,   m_data);
        check({tag, "_to"},   32'(loadTimeout),  32'(m_to));
    endtask

    // Load value from plain shift/mask arithmetic
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] al,
                                             input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * al)) & 32'h0000_00FF;
        h = (w >> (16 * (al / 2))) & 32'h0000_FFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid_mem = 1'b0; MemRead_mem = 1'b0; dmem_rvalid = 1'b0;
        #1 check("rst_stall", 32'(stall_mem), 32'd0);
        @(posedge clk); #1;
        m_rw = 1'b0; m_rd = '0; m_data = '0; m_to = 1'b0;
        check_wb("rst");
        @(negedge clk) rst = 1'b0;
    endtask

    // One instruction in MEM; memory answers lat cycles after it arrives (lat>T: never)
    task automatic run_instr(input string tag, input logic v, input logic rw, input logic [4:0] rd,
                             input logic mr, input logic [2:0] f3, input logic [1:0] al,
                             input logic [1:0] ws, input logic [31:0] alu, input logic [31:0] pc,
                             input logic [31:0] rdata, input int lat);
        bit done;
        bit is_load;
        bit exp_stall;
        logic [31:0] drv;
        logic [31:0] sel;
        is_load = v && mr;
        done = 0;
        for (int k = 0; k <= int'(T) && !done; k++) begin
            @(negedge clk);
            rst = 1'b0;
            valid_mem = v; RegWrite_mem = rw; rdAddr_mem = rd; MemRead_mem = mr;
            funct3_mem = f3; addrLow_mem = al; WbSel_mem = ws;
            AluResult_mem = alu; PcPlus4_mem = pc;
            if (is_load) begin
                dmem_rvalid = (k == lat);
                drv = (k == lat) ? rdata : $urandom;
            end else begin
                dmem_rvalid = 1'($urandom_range(0, 1));
                drv = $urandom;
            end
            dmem_rdata = drv;
            #1;
            exp_stall = is_load && (k < lat) && (k < int'(T));
            check({tag, "_stall"}, 32'(stall_mem), 32'(exp_stall));
            case (ws)
                2'b01:   sel = ref_load(f3, al, drv);
                2'b10:   sel = pc;
                default: sel = alu;
            endcase
            if (!v) begin
                m_rw = 1'b0; done = 1;
            end else if (!mr || k == lat) begin
                m_rw = rw && (rd != 5'd0); m_rd = rd; m_data = sel; done = 1;
            end else if (k == int'(T)) begin
                m_rw = 1'b0; m_to = 1'b1; done = 1;
            end else begin
                m_rw = 1'b0;
            end
            @(posedge clk); #1;
            check_wb(tag);
        end
        if (!done) check({tag, "_unterminated"}, 32'd1, 32'd0);
    endtask

    initial begin
        rst = 1'b1; valid_mem = 1'b0; RegWrite_mem = 1'b0; rdAddr_mem = '0; MemRead_mem = 1'b0;
        funct3_mem = '0; addrLow_mem = '0; WbSel_mem = '0; AluResult_mem = '0;
        PcPlus4_mem = '0; dmem_rdata = '0; dmem_rvalid = 1'b0;
        m_rw = 1'b0; m_rd = '0; m_data = '0; m_to = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        run_instr("alu",  1, 1, 5'd5, 0, 3'd0, 2'd0, 2'b00, 32'h0000_1234, 32'h0, 32'h0, 0);
        run_instr("lb",   1, 1, 5'd7, 1, 3'd0, 2'd3, 2'b01, 32'h0, 32'h0, 32'h80AA_BBCC, 0);
        run_instr("lbu",  1, 1, 5'd7, 1, 3'd4, 2'd3, 2'b01, 32'h0, 32'h0, 32'h80AA_BBCC, 0);
        run_instr("lhu",  1, 1, 5'd8, 1, 3'd5, 2'd2, 2'b01, 32'h0, 32'h0, 32'h80AA_BBCC, 0);
        run_instr("lw3",  1, 1, 5'd9, 1, 3'd2, 2'd0, 2'b01, 32'h0, 32'h0, 32'hDEAD_BEEF, 3);
        run_instr("tmo",  1, 1, 5'd10, 1, 3'd2, 2'd0, 2'b01, 32'h0, 32'h0, 32'h1111_2222, NEVER);
        run_instr("stky", 1, 1, 5'd11, 0, 3'd0, 2'd0, 2'b00, 32'h55, 32'h0, 32'h0, 0);
        do_reset();
        run_instr("tmod", 1, 1, 5'd12, 1, 3'd2, 2'd0, 2'b01, 32'h0, 32'h0, 32'hCAFE_F00D, int'(T));
        run_instr("jal0", 1, 1, 5'd0, 0, 3'd0, 2'd0, 2'b10, 32'h77, 32'h104, 32'h0, 0);
        run_instr("jal1", 1, 1, 5'd1, 0, 3'd0, 2'd0, 2'b10, 32'h77, 32'h104, 32'h0, 0);

        // Reset while a load is waiting discards it
        @(negedge clk);
        valid_mem = 1'b1; RegWrite_mem = 1'b1; rdAddr_mem = 5'd13; MemRead_mem = 1'b1;
        funct3_mem = 3'd2; WbSel_mem = 2'b01; dmem_rvalid = 1'b0;
        #1 check("rw_stall0", 32'(stall_mem), 32'd1);
        @(posedge clk); #1; m_rw = 1'b0; check_wb("rw_c0");
        @(negedge clk); #1 check("rw_stall1", 32'(stall_mem), 32'd1);
        @(posedge clk); #1; check_wb("rw_c1");
        @(negedge clk); rst = 1'b1;
        #1 check("rw_stall_rst", 32'(stall_mem), 32'd0);
        @(posedge clk); #1;
        m_rw = 1'b0; m_rd = '0; m_data = '0; m_to = 1'b0;
        check_wb("rw_rst");
        @(negedge clk); rst = 1'b0; valid_mem = 1'b0;
        #1 check("rw_stall_post", 32'(stall_mem), 32'd0);
        @(posedge clk); #1; check_wb("rw_post");
        run_instr("rw_alu", 1, 1, 5'd14, 0, 3'd0, 2'd0, 2'b00, 32'hABCD_0001, 32'h0, 32'h0, 0);
        run_instr("rw_lw0", 1, 1, 5'd15, 1, 3'd2, 2'd0, 2'b01, 32'h0, 32'h0, 32'h1357_9BDF, 0);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 19) == 0) do_reset();
            run_instr("rnd",
                      1'($urandom_range(0, 99) < 85), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      $urandom, $urandom, $urandom, $urandom_range(0, 6));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
